// File: rtl/uart_pkg.sv
// Shared UART package: receiver FSM state encoding, the default oversample
// ratio and a parity helper used by the receiver datapath.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int RX_OVERSAMPLE_DEF = 16;

    // True when the received parity bit does not match the selected sense.
    // data_xor is the XOR reduction of the data bits; odd selects odd parity.
    function automatic logic parity_mismatch(input logic data_xor,
                                             input logic par_bit,
                                             input logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Front end of the UART receiver: a 2-flop synchronizer for the asynchronous
// serial line and a rising-edge detector on the baud generator's RX tick.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   rx_tick       RX tick square wave, synchronous to clk
//   rx_serial     asynchronous serial line, idles high
//   rx_s          synchronized serial line
//   stb           one-clk sample strobe per tick period
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_tick,
    input  logic rx_serial,
    output logic rx_s,
    output logic stb
);

    logic rx_meta;
    logic tick_d;

    // Synchronizer flops reset to the idle-high line level so reset never
    // looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // Registered rising-edge detect: the tick is high for more than one clk,
    // so stb is a single-clk pulse once per tick period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_d <= 1'b0;
            stb    <= 1'b0;
        end else begin
            tick_d <= rx_tick;
            stb    <= rx_tick & ~tick_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples the serial line on strobes derived from the
// baud generator tick, recovers an LSB-first frame (start, data, optional
// parity, stop) and presents the byte with a one-clk valid and error flags.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   i_Rx_ClkTick   RX tick square wave from the baud rate generator
//   i_Rx_Serial    asynchronous serial line, idles high
//   o_Rx_Data      last received data, LSB = first bit on the line
//   o_Rx_Valid     one-clk pulse when data and error flags update
//   o_Frame_Err    stop bit sampled low in the last frame
//   o_Parity_Err   parity mismatch in the last frame
//   o_Busy         high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int RX_OVERSAMPLE = RX_OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_Rx_ClkTick,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy
);

    localparam int SW = $clog2(RX_OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] MID_START = SW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_BIT   = SW'(RX_OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    logic rx_s;
    logic stb;

    rx_state_t            state, state_n;
    logic [SW-1:0]        scnt, scnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 armed, armed_n;
    logic                 par_err, par_err_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 ferr_n, perr_n, valid_n;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_tick  (i_Rx_ClkTick),
        .rx_serial(i_Rx_Serial),
        .rx_s     (rx_s),
        .stb      (stb)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            scnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            armed        <= 1'b0;
            par_err      <= 1'b0;
            o_Rx_Data    <= '0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Rx_Valid   <= 1'b0;
        end else begin
            state        <= state_n;
            scnt         <= scnt_n;
            bcnt         <= bcnt_n;
            shreg        <= shreg_n;
            armed        <= armed_n;
            par_err      <= par_err_n;
            o_Rx_Data    <= data_n;
            o_Frame_Err  <= ferr_n;
            o_Parity_Err <= perr_n;
            o_Rx_Valid   <= valid_n;
        end
    end

    // Everything advances only on stb. A start edge is accepted only after the
    // line has been seen high in IDLE (armed), so a held-low line or break
    // cannot retrigger. The frame ends at mid-stop; the rest of the stop bit
    // is spent in IDLE, which also re-arms for the next start edge.
    always_comb begin
        state_n   = state;
        scnt_n    = scnt;
        bcnt_n    = bcnt;
        shreg_n   = shreg;
        armed_n   = armed;
        par_err_n = par_err;
        data_n    = o_Rx_Data;
        ferr_n    = o_Frame_Err;
        perr_n    = o_Parity_Err;
        valid_n   = 1'b0;

        case (state)
            IDLE: begin
                if (stb) begin
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        scnt_n  = '0;
                        armed_n = 1'b0;
                    end
                end
            end
            START: begin
                if (stb) begin
                    if (scnt == MID_START) begin
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            scnt_n  = '0;
                            bcnt_n  = '0;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (stb) begin
                    scnt_n = (scnt == MID_BIT) ? '0 : scnt + 1'b1;
                    if (scnt == MID_BIT) begin
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        bcnt_n  = bcnt + 1'b1;
                        if (bcnt == LAST_BIT) begin
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
            end
            PARITY: begin
                if (stb) begin
                    scnt_n = (scnt == MID_BIT) ? '0 : scnt + 1'b1;
                    if (scnt == MID_BIT) begin
                        par_err_n = parity_mismatch(^shreg, rx_s, PAR_ODD);
                        state_n   = STOP;
                    end
                end
            end
            STOP: begin
                if (stb) begin
                    scnt_n = (scnt == MID_BIT) ? '0 : scnt + 1'b1;
                    if (scnt == MID_BIT) begin
                        data_n  = shreg;
                        ferr_n  = ~rx_s;
                        perr_n  = (PARITY_EN != 0) && par_err;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: an 8N1 receiver and an 8E1 receiver share clock,
// reset and tick; each has its own serial line. Received frames are
// collected into queues and compared with the values the bench sent.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] tdiv = 2'd0;
    logic       tick;
    logic       rx_line = 1'b1;
    logic       rx_line_p = 1'b1;

    logic [7:0] rx_data, rx_data_p;
    logic       valid, frame_err, parity_err, busy;
    logic       valid_p, frame_err_p, parity_err_p, busy_p;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rec_t;

    rec_t q[$];
    rec_t qp[$];
    int   total = 0;
    int   bad = 0;
    int   dbl = 0;
    logic prev_v = 1'b0;
    logic prev_vp = 1'b0;

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .RX_OVERSAMPLE(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Rx_ClkTick(tick),
        .i_Rx_Serial (rx_line),
        .o_Rx_Data   (rx_data),
        .o_Rx_Valid  (valid),
        .o_Frame_Err (frame_err),
        .o_Parity_Err(parity_err),
        .o_Busy      (busy)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .RX_OVERSAMPLE(16)) dut_p (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Rx_ClkTick(tick),
        .i_Rx_Serial (rx_line_p),
        .o_Rx_Data   (rx_data_p),
        .o_Rx_Valid  (valid_p),
        .o_Frame_Err (frame_err_p),
        .o_Parity_Err(parity_err_p),
        .o_Busy      (busy_p)
    );

    always #5 clk = ~clk;

    // Tick toggles every 2 clk, giving one strobe every 4 clk.
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign tick = tdiv[1];

    // Collect every valid pulse and note any pulse lasting two clks.
    always @(negedge clk) begin
        if (valid) q.push_back(rec_t'({rx_data, frame_err, parity_err}));
        if (valid_p) qp.push_back(rec_t'({rx_data_p, frame_err_p, parity_err_p}));
        if ((valid && prev_v) || (valid_p && prev_vp)) dbl++;
        prev_v  = valid;
        prev_vp = valid_p;
    end

    // Reference parity rule: even parity wants an even count of ones over
    // data plus parity bit, odd parity an odd count.
    function automatic logic exp_perr(input logic [7:0] d, input logic p, input logic odd);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(odd);
    endfunction

    task automatic drive_bit(input bit sel, input logic v, input int n);
        if (sel) rx_line_p = v;
        else rx_line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT_CLK);
        if (with_par) drive_bit(sel, par_bit, BIT_CLK);
        drive_bit(sel, stop_bit, BIT_CLK);
    endtask

    task automatic test_reset();
        total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr: got %b expected 0", parity_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (busy_p !== 1'b0 || rx_data_p !== 8'h00) begin bad++; $display("[TB] FAIL reset_par_dut: got busy=%b data=%h expected 0/00", busy_p, rx_data_p); end
    endtask

    // Receive a single frame on the 8N1 receiver and check it against the model.
    task automatic check_one(input string name, input logic [7:0] d, input logic stop_bit);
        rec_t r;
        total++;
        if (q.size() !== 1) begin bad++; $display("[TB] FAIL %s_count: got %0d expected 1", name, q.size()); end
        if (q.size() > 0) begin
            r = q.pop_front();
            total++; if (r.data !== d) begin bad++; $display("[TB] FAIL %s_data: got %h expected %h", name, r.data, d); end
            total++; if (r.ferr !== ~stop_bit) begin bad++; $display("[TB] FAIL %s_ferr: got %b expected %b", name, r.ferr, ~stop_bit); end
            total++; if (r.perr !== 1'b0) begin bad++; $display("[TB] FAIL %s_perr: got %b expected 0", name, r.perr); end
        end
        q.delete();
    endtask

    task automatic test_basic();
        q.delete();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 100);
        check_one("basic_a5", 8'hA5, 1'b1);
    endtask

    task automatic test_glitch();
        q.delete();
        drive_bit(0, 1'b0, 15);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_rise: got %b expected 1", busy); end
        drive_bit(0, 1'b0, 5);
        drive_bit(0, 1'b1, 60);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_fall: got %b expected 0", busy); end
        total++; if (q.size() !== 0) begin bad++; $display("[TB] FAIL glitch_no_valid: got %0d frames expected 0", q.size()); end
        drive_bit(0, 1'b1, 100);
    endtask

    task automatic test_frame_err();
        q.delete();
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 2000);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL break_busy: got %b expected 0", busy); end
        check_one("frame_err_3c", 8'h3C, 1'b0);
        drive_bit(0, 1'b1, 200);
        send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 100);
        check_one("after_break_c3", 8'hC3, 1'b1);
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       p;
        rec_t       r;
        qp.delete();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin d = 8'h07; p = 1'b1; end
            else if (i == 1) begin d = 8'h07; p = 1'b0; end
            else begin d = 8'($urandom); p = 1'($urandom); end
            send_frame(1, d, 1, p, 1'b1);
            drive_bit(1, 1'b1, $urandom_range(0, 100));
            total++;
            if (qp.size() !== 1) begin bad++; $display("[TB] FAIL parity_count[%0d]: got %0d expected 1", i, qp.size()); end
            if (qp.size() > 0) begin
                r = qp.pop_front();
                total++; if (r.data !== d) begin bad++; $display("[TB] FAIL parity_data[%0d]: got %h expected %h", i, r.data, d); end
                total++; if (r.perr !== exp_perr(d, p, 1'b0)) begin bad++; $display("[TB] FAIL parity_perr[%0d]: got %b expected %b (d=%h p=%b)", i, r.perr, exp_perr(d, p, 1'b0), d, p); end
                total++; if (r.ferr !== 1'b0) begin bad++; $display("[TB] FAIL parity_ferr[%0d]: got %b expected 0", i, r.ferr); end
            end
            qp.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        rec_t       r;
        q.delete();
        exp_q = '{8'h55, 8'hAA, 8'hFF};
        foreach (exp_q[i]) send_frame(0, exp_q[i], 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 100);
        total++;
        if (q.size() !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 3", q.size()); end
        foreach (exp_q[i]) begin
            if (q.size() > 0) begin
                r = q.pop_front();
                total++; if (r.data !== exp_q[i] || r.ferr !== 1'b0) begin bad++; $display("[TB] FAIL b2b_frame[%0d]: got %h/ferr=%b expected %h/0", i, r.data, r.ferr, exp_q[i]); end
            end
        end
        total++; if (dbl !== 0) begin bad++; $display("[TB] FAIL valid_width: got %0d double pulses expected 0", dbl); end
        q.delete();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       s;
        for (int i = 0; i < 12; i++) begin
            q.delete();
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(0, d, 0, 1'b0, s);
            drive_bit(0, 1'b1, s ? $urandom_range(0, 100) : $urandom_range(16, 100));
            check_one("random", d, s);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        q.delete();
        d = 8'h5A;
        drive_bit(0, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], BIT_CLK);
        drive_bit(0, d[4], 32);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midframe_busy: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        total++; if (rx_data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
            bad++; $display("[TB] FAIL midframe_outputs: got data=%h v=%b fe=%b pe=%b expected 00/0/0/0", rx_data, valid, frame_err, parity_err);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midframe_busy_clear: got %b expected 0", busy); end
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        drive_bit(0, 1'b1, 500);
        total++; if (q.size() !== 0) begin bad++; $display("[TB] FAIL midframe_no_valid: got %0d frames expected 0", q.size()); end
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        drive_bit(0, 1'b1, 100);
        check_one("after_reset_81", 8'h81, 1'b1);
    endtask

    initial begin
        reset_n   = 1'b0;
        rx_line   = 1'b1;
        rx_line_p = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
